// File: rtl/button_debounce.sv
// Debounces a raw board input pin into a clean level, one-cycle press and
// release strobes, and a modulo-256 tally of accepted presses.
module button_debounce #(
   parameter int CNT_WIDTH  = 16,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       I,
   output logic       O,
   output logic       PRESS,
   output logic       RELEASE,
   output logic [7:0] COUNT
);

   typedef enum logic [1:0] {
      STABLE_LO,
      WAIT_HI,
      STABLE_HI,
      WAIT_LO
   } state_t;

   localparam logic [CNT_WIDTH-1:0] MAX = '1;
   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                 meta;
   logic                 sync;
   logic                 s;
   logic [CNT_WIDTH-1:0] cnt;
   state_t               state;

   // Flops reset to the idle pin level so reset never looks like a press.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         meta <= ACTIVE_LOW;
         sync <= ACTIVE_LOW;
      end else begin
         meta <= I;
         sync <= meta;
      end
   end

   assign s = sync ^ ACTIVE_LOW;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state   <= STABLE_LO;
         cnt     <= '0;
         O       <= 1'b0;
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         COUNT   <= 8'd0;
      end else begin
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (s) begin
                  state <= WAIT_HI;
                  cnt   <= '0;
               end
            end
            WAIT_HI: begin
               if (!s) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (cnt == MAX) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
                  O     <= 1'b1;
                  PRESS <= 1'b1;
                  COUNT <= COUNT + 8'd1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            STABLE_HI: begin
               if (!s) begin
                  state <= WAIT_LO;
                  cnt   <= '0;
               end
            end
            WAIT_LO: begin
               if (s) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (cnt == MAX) begin
                  state   <= STABLE_LO;
                  cnt     <= '0;
                  O       <= 1'b0;
                  RELEASE <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with a 16-cycle window: reset, press,
// release with glitch, bounce, tally wrap, async reset and active-low pin.
module tb_button_debounce;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic       I = 1'b0;
   logic       O;
   logic       PRESS;
   logic       RELEASE;
   logic [7:0] COUNT;

   logic       i_al = 1'b1;
   logic       o_al;
   logic       press_al;
   logic       release_al;
   logic [7:0] count_al;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   button_debounce #(.CNT_WIDTH(4), .ACTIVE_LOW(1'b0)) u_dut (
      .CLK(CLK), .RESETN(RESETN), .I(I),
      .O(O), .PRESS(PRESS), .RELEASE(RELEASE), .COUNT(COUNT)
   );

   button_debounce #(.CNT_WIDTH(4), .ACTIVE_LOW(1'b1)) u_dut_al (
      .CLK(CLK), .RESETN(RESETN), .I(i_al),
      .O(o_al), .PRESS(press_al), .RELEASE(release_al), .COUNT(count_al)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      I = 1'b0;
      RESETN = 1'b0;
      step();
      step();
      RESETN = 1'b1;
      step();
   endtask

   task automatic test_reset();
      I = 1'b0;
      RESETN = 1'b0;
      #2;
      checks++;
      if ({O, PRESS, RELEASE, COUNT} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state: got O=%b P=%b R=%b C=%0d want 0",
                  O, PRESS, RELEASE, COUNT);
      end
      step();
      RESETN = 1'b1;
      for (int k = 0; k < 100; k++) begin
         step();
         checks++;
         if ({O, PRESS, RELEASE, COUNT} !== 11'd0) begin
            errors++;
            $display("FAIL idle_low cyc%0d: got O=%b P=%b R=%b C=%0d want 0",
                     k, O, PRESS, RELEASE, COUNT);
         end
      end
   endtask

   task automatic test_press();
      I = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         step();
         checks++;
         if (O !== (k >= 19) || PRESS !== (k == 19) || RELEASE !== 1'b0) begin
            errors++;
            $display("FAIL press k=%0d: got O=%b P=%b R=%b want O=%b P=%b R=0",
                     k, O, PRESS, RELEASE, k >= 19, k == 19);
         end
      end
      checks++;
      if (COUNT !== 8'd1) begin
         errors++;
         $display("FAIL press_count: got %0d want 1", COUNT);
      end
   endtask

   task automatic test_release_glitch();
      I = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         step();
         checks++;
         if (O !== (k < 19) || RELEASE !== (k == 19) || PRESS !== 1'b0) begin
            errors++;
            $display("FAIL release k=%0d: got O=%b P=%b R=%b want O=%b P=0 R=%b",
                     k, O, PRESS, RELEASE, k < 19, k == 19);
         end
      end
      I = 1'b1;
      for (int k = 1; k <= 20; k++) step();
      checks++;
      if (O !== 1'b1 || COUNT !== 8'd2) begin
         errors++;
         $display("FAIL repress: got O=%b C=%0d want O=1 C=2", O, COUNT);
      end
      // One-cycle high at wait count 10 restarts the window: fall at 31.
      for (int k = 1; k <= 35; k++) begin
         I = (k == 12);
         step();
         checks++;
         if (O !== (k < 31) || RELEASE !== (k == 31) || PRESS !== 1'b0) begin
            errors++;
            $display("FAIL glitch k=%0d: got O=%b P=%b R=%b want O=%b P=0 R=%b",
                     k, O, PRESS, RELEASE, k < 31, k == 31);
         end
      end
      checks++;
      if (COUNT !== 8'd2) begin
         errors++;
         $display("FAIL release_count: got %0d want 2", COUNT);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         I = ((i / 3) % 2 == 0);
         step();
         checks++;
         if (O !== 1'b0 || PRESS !== 1'b0 || RELEASE !== 1'b0) begin
            errors++;
            $display("FAIL bounce i=%0d: got O=%b P=%b R=%b want 0",
                     i, O, PRESS, RELEASE);
         end
      end
      I = 1'b1;
      for (int k = 1; k <= 22; k++) begin
         step();
         checks++;
         if (O !== (k >= 19) || PRESS !== (k == 19) || RELEASE !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle k=%0d: got O=%b P=%b want O=%b P=%b",
                     k, O, PRESS, k >= 19, k == 19);
         end
      end
      checks++;
      if (COUNT !== 8'd1) begin
         errors++;
         $display("FAIL bounce_count: got %0d want 1", COUNT);
      end
   endtask

   task automatic test_wrap();
      int presses;
      logic [7:0] want;
      do_reset();
      for (int n = 1; n <= 257; n++) begin
         presses = 0;
         I = 1'b1;
         for (int k = 0; k < 20; k++) begin
            step();
            if (PRESS === 1'b1) presses++;
         end
         I = 1'b0;
         for (int k = 0; k < 20; k++) begin
            step();
            if (PRESS === 1'b1) presses++;
         end
         want = 8'(n % 256);
         checks++;
         if (COUNT !== want || presses != 1 || O !== 1'b0) begin
            errors++;
            $display("FAIL wrap n=%0d: got C=%0d presses=%0d O=%b want C=%0d 1 O=0",
                     n, COUNT, presses, O, want);
         end
      end
   endtask

   task automatic test_async_reset();
      I = 1'b1;
      for (int k = 0; k < 11; k++) step();
      #2;
      RESETN = 1'b0;
      #1;
      checks++;
      if ({O, PRESS, RELEASE, COUNT} !== 11'd0) begin
         errors++;
         $display("FAIL async_reset: got O=%b P=%b R=%b C=%0d want 0",
                  O, PRESS, RELEASE, COUNT);
      end
      step();
      RESETN = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         step();
         checks++;
         if (O !== (k >= 19) || PRESS !== (k == 19)) begin
            errors++;
            $display("FAIL post_reset k=%0d: got O=%b P=%b want O=%b P=%b",
                     k, O, PRESS, k >= 19, k == 19);
         end
      end
   endtask

   task automatic test_active_low();
      i_al = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step();
         checks++;
         if (o_al !== 1'b0 || press_al !== 1'b0 || count_al !== 8'd0) begin
            errors++;
            $display("FAIL al_idle k=%0d: got O=%b P=%b C=%0d want 0",
                     k, o_al, press_al, count_al);
         end
      end
      i_al = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         step();
         checks++;
         if (o_al !== (k >= 19) || press_al !== (k == 19)) begin
            errors++;
            $display("FAIL al_press k=%0d: got O=%b P=%b want O=%b P=%b",
                     k, o_al, press_al, k >= 19, k == 19);
         end
      end
      checks++;
      if (count_al !== 8'd1) begin
         errors++;
         $display("FAIL al_count: got %0d want 1", count_al);
      end
   endtask

   always @(negedge CLK) begin
      if (RESETN && PRESS === 1'b1 && RELEASE === 1'b1) begin
         errors++;
         checks++;
         $display("FAIL strobe_overlap: got P=1 R=1 want not both");
      end
   end

   initial begin
      test_reset();
      test_press();
      test_release_glitch();
      test_bounce();
      test_wrap();
      test_async_reset();
      test_active_low();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
